radio_timing_tx: RTL and testbench

RADIO_TIMING_TX -- requirements
Module: radio_timing_tx

---
 rtl/radio_timing_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_radio_timing_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/radio_timing_tx.sv
// radio_timing_tx
//
// Sequences one radio receive burst toward a timing-engine port:
//   IDLE -> WARMUP -> RX -> GUARD -> IDLE
// RX and GUARD are skipped when their captured duration is zero. WARMUP
// always lasts at least one cycle. A single down-counter times every phase.
// It is loaded with N-1 when a phase is entered, and the phase ends on the
// cycle the counter reads zero, so an all-ones N never wraps.
//
// Ports
//   ck              rising-edge clock
//   arst            asynchronous, active-high reset
//   isolateM1M2     isolation request: aborts a running burst and blocks starts
//   start           burst request, sampled only in IDLE
//   warmupCycles    warm-up length, captured when a start is accepted
//   rxCycles        receive-window length, captured when a start is accepted
//   guardCycles     post-burst guard length, captured when a start is accepted
//   radioEnableReq  registered radio-enable request (WARMUP and RX)
//   radioRxEnReq    registered rx-enable request (RX only)
//   busy            registered, high whenever the FSM is not in IDLE
//   done            registered one-cycle pulse on normal completion
//   aborted         registered one-cycle pulse when isolation ends a burst
//
// Every output comes from a flop that is computed from the next state.
// No input reaches an output combinationally.

module radio_timing_tx #(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             isolateM1M2,
  input  logic             start,
  input  logic [CNT_W-1:0] warmupCycles,
  input  logic [CNT_W-1:0] rxCycles,
  input  logic [CNT_W-1:0] guardCycles,
  output logic             radioEnableReq,
  output logic             radioRxEnReq,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RX     = 2'd2,
    GUARD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Counter load value for a phase of n cycles. A zero length is treated as
  // one cycle. Only WARMUP relies on that, because the zero-length RX and
  // GUARD phases are skipped before they are loaded.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] v;
    if (n == CNT_ZERO) begin
      v = CNT_ZERO;
    end else begin
      v = n - CNT_ONE;
    end
    return v;
  endfunction

  state_t           state_r,    state_nxt_s;
  logic [CNT_W-1:0] cnt_r,      cnt_nxt_s;
  logic [CNT_W-1:0] rx_len_r,   rx_len_nxt_s;
  logic [CNT_W-1:0] guard_len_r, guard_len_nxt_s;
  logic             en_r,       en_nxt_s;
  logic             rx_en_r,    rx_en_nxt_s;
  logic             busy_r,     busy_nxt_s;
  logic             done_r,     done_nxt_s;
  logic             aborted_r,  aborted_nxt_s;

  // Next-state, counter and captured-duration logic, plus the registered-output decode.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rx_len_nxt_s    = rx_len_r;
    guard_len_nxt_s = guard_len_r;
    done_nxt_s      = 1'b0;
    aborted_nxt_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (start && !isolateM1M2) begin
          // The warm-up length goes straight into the counter. Only the
          // later phases need a stored copy.
          state_nxt_s     = WARMUP;
          cnt_nxt_s       = load_val(warmupCycles);
          rx_len_nxt_s    = rxCycles;
          guard_len_nxt_s = guardCycles;
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end

      WARMUP: begin
        if (isolateM1M2) begin
          state_nxt_s   = IDLE;
          cnt_nxt_s     = CNT_ZERO;
          aborted_nxt_s = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          if (rx_len_r != CNT_ZERO) begin
            state_nxt_s = RX;
            cnt_nxt_s   = load_val(rx_len_r);
          end else if (guard_len_r != CNT_ZERO) begin
            state_nxt_s = GUARD;
            cnt_nxt_s   = load_val(guard_len_r);
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
            done_nxt_s  = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end

      RX: begin
        if (isolateM1M2) begin
          state_nxt_s   = IDLE;
          cnt_nxt_s     = CNT_ZERO;
          aborted_nxt_s = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          if (guard_len_r != CNT_ZERO) begin
            state_nxt_s = GUARD;
            cnt_nxt_s   = load_val(guard_len_r);
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
            done_nxt_s  = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end

      GUARD: begin
        if (isolateM1M2) begin
          state_nxt_s   = IDLE;
          cnt_nxt_s     = CNT_ZERO;
          aborted_nxt_s = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase

    // Decoding from the next state lets the output flops line up with the
    // state register. The rx enable is a subset of the radio enable, so it
    // can never be high on its own.
    en_nxt_s    = (state_nxt_s == WARMUP) || (state_nxt_s == RX);
    rx_en_nxt_s = (state_nxt_s == RX);
    busy_nxt_s  = (state_nxt_s != IDLE);
  end

  // State, counter, captured durations and output flops with asynchronous reset.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      rx_len_r    <= CNT_ZERO;
      guard_len_r <= CNT_ZERO;
      en_r        <= 1'b0;
      rx_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rx_len_r    <= rx_len_nxt_s;
      guard_len_r <= guard_len_nxt_s;
      en_r        <= en_nxt_s;
      rx_en_r     <= rx_en_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      aborted_r   <= aborted_nxt_s;
    end
  end

  assign radioEnableReq = en_r;
  assign radioRxEnReq   = rx_en_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign aborted        = aborted_r;

  radio_timing_tx_chk u_chk (
    .ck             (ck),
    .arst           (arst),
    .radioEnableReq (en_r),
    .radioRxEnReq   (rx_en_r),
    .busy           (busy_r),
    .done           (done_r),
    .aborted        (aborted_r)
  );

endmodule

// radio_timing_tx_chk
// Output-relationship properties of radio_timing_tx. It is passive: every
// port is an input, and it only observes the registered outputs.
module radio_timing_tx_chk (
  input logic ck,
  input logic arst,
  input logic radioEnableReq,
  input logic radioRxEnReq,
  input logic busy,
  input logic done,
  input logic aborted
);

  // The rx enable may only be high together with the radio enable.
  a_rx_implies_en : assert property (@(posedge ck) disable iff (arst)
    radioRxEnReq |-> radioEnableReq);

  // A burst ends either normally or by abort, never both at once.
  a_done_xor_abort : assert property (@(posedge ck) disable iff (arst)
    !(done && aborted));

  // The completion pulses only appear in the first IDLE cycle.
  a_pulse_not_busy : assert property (@(posedge ck) disable iff (arst)
    (done || aborted) |-> !busy);

endmodule

// File: tb/tb_radio_timing_tx.sv
module tb_radio_timing_tx;

  logic       ck = 1'b0;
  logic       arst;
  logic       iso;
  logic       start;
  logic [7:0] w8, r8, g8;
  logic [3:0] w4, r4, g4;
  logic       en8, rx8, busy8, done8, ab8;
  logic       en4, rx4, busy4, done4, ab4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 ck = ~ck;

  radio_timing_tx #(.CNT_W(8)) dut (
    .ck(ck), .arst(arst), .isolateM1M2(iso), .start(start),
    .warmupCycles(w8), .rxCycles(r8), .guardCycles(g8),
    .radioEnableReq(en8), .radioRxEnReq(rx8), .busy(busy8),
    .done(done8), .aborted(ab8)
  );

  radio_timing_tx #(.CNT_W(4)) dut4 (
    .ck(ck), .arst(arst), .isolateM1M2(iso), .start(start),
    .warmupCycles(w4), .rxCycles(r4), .guardCycles(g4),
    .radioEnableReq(en4), .radioRxEnReq(rx4), .busy(busy4),
    .done(done4), .aborted(ab4)
  );

  // Reference model of the CNT_W=8 instance. It tracks the cycle offset k
  // inside the current burst. With W = max(w,1), the radio enable covers
  // k in 1..W+R, the rx enable covers W+1..W+R, busy covers 1..W+R+G, and
  // done arrives at k = W+R+G+1.
  bit m_act = 1'b0;
  int m_k = 0, m_W = 0, m_R = 0, m_G = 0;
  bit m_done = 1'b0, m_ab = 1'b0;

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_done = 1'b0; m_ab = 1'b0;
  endtask

  task automatic model_edge();
    if (arst) begin
      model_reset();
    end else begin
      m_done = 1'b0; m_ab = 1'b0;
      if (m_act) begin
        if (iso) begin
          m_act = 1'b0; m_ab = 1'b1;
        end else begin
          m_k++;
          if (m_k > m_W + m_R + m_G) begin
            m_act = 1'b0; m_done = 1'b1;
          end
        end
      end else if (start && !iso) begin
        m_act = 1'b1; m_k = 1;
        m_W = (w8 == 8'd0) ? 1 : int'(w8);
        m_R = int'(r8); m_G = int'(g8);
      end
    end
  endtask

  function automatic int model_vec();
    bit e, x;
    e = m_act && (m_k <= m_W + m_R);
    x = m_act && (m_k > m_W) && (m_k <= m_W + m_R);
    return {27'd0, e, x, m_act, m_done, m_ab};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance one clock, update the model, then compare at the edge + 1.
  // The packed value is {en, rx, busy, done, aborted}.
  task automatic step();
    @(posedge ck);
    model_edge();
    #1;
    chk("cycle{en,rx,busy,done,ab}",
        {27'd0, en8, rx8, busy8, done8, ab8}, model_vec());
  endtask

  typedef struct {
    int w, r, g, iso_k;
    int exp_en, exp_rx, exp_busy, exp_done_at, exp_ab_at;
  } vec_t;

  // Start one burst and tally the outputs over every cycle of it.
  task automatic run_vec(input vec_t v, input int idx);
    int en_c = 0, rx_c = 0, busy_c = 0, done_at = 0, ab_at = 0, bad = 0;
    int lim;
    lim = ((v.w == 0) ? 1 : v.w) + v.r + v.g + 3;
    w8 = 8'(v.w); r8 = 8'(v.r); g8 = 8'(v.g); iso = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      en_c += int'(en8); rx_c += int'(rx8); busy_c += int'(busy8);
      if (done8 && done_at == 0) done_at = k;
      if (ab8 && ab_at == 0) ab_at = k;
      if (rx8 && !en8) bad++;
      // Change the live inputs mid-burst. The running burst must ignore them.
      if (k == 2) begin w8 = 8'd9; r8 = 8'd9; g8 = 8'd9; end
      iso = (k == v.iso_k);
      if (k < lim) step();
    end
    iso = 1'b0;
    chk($sformatf("vec%0d en_cycles", idx), en_c, v.exp_en);
    chk($sformatf("vec%0d rx_cycles", idx), rx_c, v.exp_rx);
    chk($sformatf("vec%0d busy_cycles", idx), busy_c, v.exp_busy);
    chk($sformatf("vec%0d done_at", idx), done_at, v.exp_done_at);
    chk($sformatf("vec%0d aborted_at", idx), ab_at, v.exp_ab_at);
    chk($sformatf("vec%0d rx_without_en", idx), bad, 0);
  endtask

  // Count the outputs of the CNT_W=4 instance over one burst.
  task automatic run4(input int w, input int r, input int g, input int e_en,
                      input int e_rx, input int e_busy, input int e_done);
    int en_c = 0, rx_c = 0, busy_c = 0, done_at = 0;
    w4 = 4'(w); r4 = 4'(r); g4 = 4'(g);
    w8 = 8'd0; r8 = 8'd0; g8 = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= e_done + 3; k++) begin
      en_c += int'(en4); rx_c += int'(rx4); busy_c += int'(busy4);
      if (done4 && done_at == 0) done_at = k;
      step();
    end
    chk($sformatf("w4 %0d/%0d/%0d en", w, r, g), en_c, e_en);
    chk($sformatf("w4 %0d/%0d/%0d rx", w, r, g), rx_c, e_rx);
    chk($sformatf("w4 %0d/%0d/%0d busy", w, r, g), busy_c, e_busy);
    chk($sformatf("w4 %0d/%0d/%0d done_at", w, r, g), done_at, e_done);
  endtask

  vec_t vecs[9];

  initial begin
    int cnt;
    bit prev_done, b2b_ok;

    //             w    r    g   iso  en   rx   busy done ab
    vecs[0] = '{   3,   4,   2,  0,   7,   4,   9,  10,  0};
    vecs[1] = '{   0,   0,   0,  0,   1,   0,   1,   2,  0};
    vecs[2] = '{   1,   0,   3,  0,   1,   0,   4,   5,  0};
    vecs[3] = '{   5,   1,   0,  0,   6,   1,   6,   7,  0};
    vecs[4] = '{ 255,   0,   0,  0, 255,   0, 255, 256,  0};
    vecs[5] = '{   1, 255, 255,  0, 256, 255, 511, 512,  0};
    vecs[6] = '{   2,  10,   0,  5,   5,   3,   5,   0,  6};
    vecs[7] = '{   4,   3,   5, 10,   7,   3,  10,   0, 11};
    vecs[8] = '{   2,   2,   0,  4,   4,   2,   4,   0,  5};

    arst = 1'b1; iso = 1'b0; start = 1'b0;
    w8 = 8'd0; r8 = 8'd0; g8 = 8'd0; w4 = 4'd0; r4 = 4'd0; g4 = 4'd0;
    #3;
    chk("reset en", int'(en8), 0);
    chk("reset rx", int'(rx8), 0);
    chk("reset busy", int'(busy8), 0);
    chk("reset done", int'(done8), 0);
    chk("reset aborted", int'(ab8), 0);
    step(); step();
    arst = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Start held while isolation is high is ignored.
    cnt = 0;
    iso = 1'b1; start = 1'b1; w8 = 8'd3; r8 = 8'd3; g8 = 8'd3;
    repeat (5) begin step(); cnt += int'(busy8); end
    chk("start_under_iso busy_cycles", cnt, 0);
    iso = 1'b0; start = 1'b0;
    step();

    // Back-to-back: start is held through the done cycle, and the durations
    // change during the first burst.
    w8 = 8'd1; r8 = 8'd1; g8 = 8'd1; start = 1'b1;
    prev_done = 1'b0; b2b_ok = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (prev_done && busy8 && en8) b2b_ok = 1'b1;
      prev_done = done8;
      if (k == 1) begin w8 = 8'd2; r8 = 8'd2; g8 = 8'd0; end
    end
    start = 1'b0;
    chk("back_to_back restart", int'(b2b_ok), 1);
    repeat (8) step();

    // Asynchronous reset in the middle of RX.
    w8 = 8'd3; r8 = 8'd6; g8 = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre-arst rx", int'(rx8), 1);
    #2 arst = 1'b1;
    #1;
    chk("async arst en", int'(en8), 0);
    chk("async arst rx", int'(rx8), 0);
    chk("async arst busy", int'(busy8), 0);
    model_reset();
    step();
    arst = 1'b0;
    cnt = 0;
    repeat (12) begin step(); cnt += int'(done8) + int'(ab8) + int'(busy8); end
    chk("post-arst quiet", cnt, 0);

    // CNT_W=4 instance with the all-ones durations.
    arst = 1'b1; model_reset(); step(); arst = 1'b0; step();
    run4(0, 15, 0, 16, 15, 16, 17);
    run4(15, 15, 15, 30, 15, 45, 46);

    // Random traffic compared against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      iso = ($urandom_range(0, 29) == 0);
      w8 = 8'($urandom_range(0, 6));
      r8 = 8'($urandom_range(0, 6));
      g8 = 8'($urandom_range(0, 6));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
